// File: rtl/axi_slave_mem.sv
// AXI4 memory target: independent write (AW/W/B) and read (AR/R) engines
// sharing one word-addressed RAM. Top 4 address bits select the slave
// upstream and are ignored here.
module axi_slave_mem #(
  parameter int unsigned ID_BITS    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_BITS   = 8,
  parameter int unsigned SIZE_BITS  = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ID_BITS-1:0]      AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [LEN_BITS-1:0]     AWLEN,
  input  logic [SIZE_BITS-1:0]    AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_BITS-1:0]      BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_BITS-1:0]      ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [LEN_BITS-1:0]     ARLEN,
  input  logic [SIZE_BITS-1:0]    ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_BITS-1:0]      RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - 4;
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W-1:0] >> OFFS_W;
  endfunction

  function automatic logic f_oor(input logic [ADDR_WIDTH-1:0] a);
    return f_idx(a) >= IDX_W'(DEPTH);
  endfunction

  function automatic logic f_bad_mode(input logic [1:0] burst, input logic [SIZE_BITS-1:0] size);
    return burst[1] || (size > SIZE_BITS'(OFFS_W));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] f_next(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic [1:0] burst,
                                                   input logic [SIZE_BITS-1:0] size);
    if (burst == 2'b00) return a;
    return a + (ADDR_WIDTH'(1) << size);
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // ---------------- write path ----------------
  wstate_e               r_wstate, w_wstate_nxt;
  logic                  r_awready, r_wready, r_bvalid;
  logic                  w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
  logic [ID_BITS-1:0]    r_aw_id, r_bid;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [LEN_BITS-1:0]   r_aw_len, r_wcnt;
  logic [SIZE_BITS-1:0]  r_aw_size;
  logic [1:0]            r_aw_burst, r_bresp;
  logic                  r_werr, r_wover;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_wbeat_oor, w_wlen_bad, w_wr_en;
  logic [MEM_AW-1:0]     w_widx;

  assign w_aw_hs     = AWVALID && r_awready;
  assign w_w_hs      = WVALID && r_wready;
  assign w_b_hs      = r_bvalid && BREADY;
  assign w_wbeat_oor = f_oor(r_aw_addr);
  assign w_wlen_bad  = (r_wcnt != r_aw_len);
  assign w_wr_en     = rst_ni && w_w_hs && !w_wbeat_oor && !r_wover;
  assign w_widx      = MEM_AW'(f_idx(r_aw_addr));

  // Write FSM state and registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
    end
  end

  // Write FSM next state
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && WLAST) w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write handshake outputs decoded from the upcoming state
  always_comb begin
    w_awready_nxt = 1'b0;
    w_wready_nxt  = 1'b0;
    w_bvalid_nxt  = 1'b0;
    case (w_wstate_nxt)
      W_IDLE:  w_awready_nxt = 1'b1;
      W_DATA:  w_wready_nxt  = 1'b1;
      W_RESP:  w_bvalid_nxt  = 1'b1;
      default: w_awready_nxt = 1'b0;
    endcase
  end

  // Write burst bookkeeping: address walk, beat count, sticky error
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_aw_id    <= '0;
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_wcnt     <= '0;
      r_werr     <= 1'b0;
      r_wover    <= 1'b0;
      r_bid      <= '0;
      r_bresp    <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_id    <= AWID;
        r_aw_addr  <= AWADDR;
        r_aw_len   <= AWLEN;
        r_aw_size  <= AWSIZE;
        r_aw_burst <= AWBURST;
        r_wcnt     <= '0;
        r_werr     <= f_bad_mode(AWBURST, AWSIZE);
        r_wover    <= 1'b0;
      end
      if (w_w_hs) begin
        r_aw_addr <= f_next(r_aw_addr, r_aw_burst, r_aw_size);
        r_wcnt    <= r_wcnt + LEN_BITS'(1);
        if (w_wbeat_oor || r_wover) r_werr <= 1'b1;
        // Last legal beat without WLAST: further beats are dropped
        if (!WLAST && !w_wlen_bad) begin
          r_wover <= 1'b1;
          r_werr  <= 1'b1;
        end
        if (WLAST) begin
          r_bid   <= r_aw_id;
          r_bresp <= (r_werr || w_wbeat_oor || r_wover || w_wlen_bad) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // Byte-lane RAM writes; storage is never reset
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (WSTRB[b]) r_mem[w_widx][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rstate_e               r_rstate, w_rstate_nxt;
  logic                  r_arready, r_rvalid, w_arready_nxt, w_rvalid_nxt;
  logic [ID_BITS-1:0]    r_rid;
  logic [ADDR_WIDTH-1:0] r_raddr, w_rld_addr;
  logic [LEN_BITS-1:0]   r_ar_len, r_rcnt, w_rld_cnt, w_rld_len;
  logic [SIZE_BITS-1:0]  r_ar_size;
  logic [1:0]            r_ar_burst, r_rresp;
  logic                  r_ar_bad, r_rlast;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_r_idle, w_ar_hs, w_r_hs, w_r_load, w_rld_bad, w_rld_err;
  logic [MEM_AW-1:0]     w_ridx;

  assign w_r_idle   = (r_rstate == R_IDLE);
  assign w_ar_hs    = ARVALID && r_arready;
  assign w_r_hs     = r_rvalid && RREADY;
  assign w_r_load   = w_ar_hs || (w_r_hs && !r_rlast);
  assign w_rld_addr = w_r_idle ? ARADDR : f_next(r_raddr, r_ar_burst, r_ar_size);
  assign w_rld_bad  = w_r_idle ? f_bad_mode(ARBURST, ARSIZE) : r_ar_bad;
  assign w_rld_err  = w_rld_bad || f_oor(w_rld_addr);
  assign w_rld_cnt  = w_r_idle ? '0 : r_rcnt + LEN_BITS'(1);
  assign w_rld_len  = w_r_idle ? ARLEN : r_ar_len;
  assign w_ridx     = MEM_AW'(f_idx(w_rld_addr));

  // Read FSM state and registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
    end
  end

  // Read FSM next state
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read handshake outputs decoded from the upcoming state
  always_comb begin
    w_arready_nxt = 1'b0;
    w_rvalid_nxt  = 1'b0;
    case (w_rstate_nxt)
      R_IDLE:  w_arready_nxt = 1'b1;
      R_DATA:  w_rvalid_nxt  = 1'b1;
      default: w_arready_nxt = 1'b0;
    endcase
  end

  // Read beat loader: fetch a beat on AR accept or on each consumed non-last beat
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rid      <= '0;
      r_raddr    <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_ar_bad   <= 1'b0;
      r_rcnt     <= '0;
      r_rlast    <= 1'b0;
      r_rresp    <= '0;
      r_rdata    <= '0;
    end else if (w_r_load) begin
      if (w_r_idle) begin
        r_rid      <= ARID;
        r_ar_len   <= ARLEN;
        r_ar_size  <= ARSIZE;
        r_ar_burst <= ARBURST;
        r_ar_bad   <= w_rld_bad;
      end
      r_raddr <= w_rld_addr;
      r_rcnt  <= w_rld_cnt;
      r_rlast <= (w_rld_cnt == w_rld_len);
      r_rresp <= w_rld_err ? 2'b10 : 2'b00;
      r_rdata <= w_rld_err ? '0 : r_mem[w_ridx];
    end else if (w_r_hs) begin
      r_rlast <= 1'b0;
    end
  end

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BID     = r_bid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RID     = r_rid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;
  assign RLAST   = r_rlast;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: a reference word memory predicts B
// responses and R beats; predictions are queued at stimulus time and
// retired as the DUT presents them.
module tb_axi_slave_mem;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_slave_mem dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } beat_t;

  int          n_chk = 0;
  int          n_fail = 0;
  beat_t       q_r[$];
  logic [5:0]  q_b[$];
  logic [31:0] mdl [1024];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Write burst of nbeats (WLAST on the final one); data beat i = base + i
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input int nbeats, input logic [3:0] strb, input logic [31:0] base,
                          input int bdelay);
    logic [31:0] a;
    logic [25:0] idx;
    logic        err, hs;
    logic [3:0]  id;
    logic [5:0]  exp_b;
    int          to;
    id  = 4'($urandom_range(0, 15));
    err = burst[1] || (nbeats - 1 != int'(len));
    a   = addr;
    for (int i = 0; i < nbeats; i++) begin
      idx = a[27:2];
      if (idx >= 26'd1024) err = 1'b1;
      else if (i <= int'(len)) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) mdl[idx[9:0]][b*8 +: 8] = 8'((base + 32'(i)) >> (8 * b));
      end
      if (burst != 2'b00) a = a + 32'd4;
    end
    q_b.push_back({id, err ? 2'b10 : 2'b00});

    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
    to = 0;
    do begin hs = AWREADY; tick(); to++; end while (!hs && to < 50);
    AWVALID = 1'b0;
    check_eq("aw_handshake", hs, 1'b1);
    check_eq("wready_after_aw", WREADY, 1'b1);
    check_eq("awready_busy", AWREADY, 1'b0);

    for (int i = 0; i < nbeats; i++) begin
      WDATA = base + 32'(i); WSTRB = strb; WLAST = (i == nbeats - 1); WVALID = 1'b1;
      to = 0;
      do begin hs = WREADY; tick(); to++; end while (!hs && to < 50);
      check_eq("w_handshake", hs, 1'b1);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check_eq("bvalid_after_wlast", BVALID, 1'b1);

    exp_b = q_b.pop_front();
    for (int d = 0; d < bdelay; d++) begin
      check_eq("bvalid_hold", BVALID, 1'b1);
      check_eq("bid_hold", BID, exp_b[5:2]);
      check_eq("awready_hold", AWREADY, 1'b0);
      tick();
    end
    BREADY = 1'b1;
    check_eq("bid", BID, exp_b[5:2]);
    check_eq("bresp", BRESP, exp_b[1:0]);
    tick();
    BREADY = 1'b0;
    check_eq("bvalid_clear", BVALID, 1'b0);
    check_eq("awready_back", AWREADY, 1'b1);
  endtask

  // Read burst; stall alternates RREADY, abort_at >= 0 resets on that beat
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input bit stall, input int abort_at);
    logic [31:0] a;
    logic [25:0] idx;
    logic        err, hs, rdy;
    logic [3:0]  id;
    beat_t       e;
    int          to, beat, cyc;
    id = 4'($urandom_range(0, 15));
    a  = addr;
    for (int i = 0; i <= int'(len); i++) begin
      idx = a[27:2];
      err = burst[1] || (idx >= 26'd1024);
      q_r.push_back('{id: id, d: err ? 32'h0 : mdl[idx[9:0]], r: err ? 2'b10 : 2'b00,
                      l: (i == int'(len))});
      if (burst != 2'b00) a = a + 32'd4;
    end

    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
    to = 0;
    do begin hs = ARREADY; tick(); to++; end while (!hs && to < 50);
    ARVALID = 1'b0;
    check_eq("ar_handshake", hs, 1'b1);
    check_eq("rvalid_after_ar", RVALID, 1'b1);

    beat = 0; cyc = 0;
    while (q_r.size() > 0 && cyc < 200) begin
      if (RVALID !== 1'b1) begin
        check_eq("rvalid_in_burst", RVALID, 1'b1);
        break;
      end
      e = q_r[0];
      check_eq("rid", RID, e.id);
      check_eq("rdata", RDATA, e.d);
      check_eq("rresp", RRESP, e.r);
      check_eq("rlast", RLAST, e.l);
      check_eq("arready_busy", ARREADY, 1'b0);
      if (beat == abort_at) begin
        rst_ni = 1'b0; RREADY = 1'b0;
        tick();
        check_eq("rvalid_in_reset", RVALID, 1'b0);
        q_r.delete();
        rst_ni = 1'b1;
        tick();
        check_eq("arready_after_reset", ARREADY, 1'b1);
        check_eq("rvalid_after_reset", RVALID, 1'b0);
        return;
      end
      rdy = stall ? cyc[0] : 1'b1;
      RREADY = rdy;
      tick();
      cyc++;
      if (rdy) begin
        void'(q_r.pop_front());
        beat++;
      end
    end
    RREADY = 1'b0;
    check_eq("rd_beats_left", 64'(q_r.size()), 64'd0);
    check_eq("rvalid_done", RVALID, 1'b0);
    check_eq("arready_done", ARREADY, 1'b1);
  endtask

  initial begin
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_awready", AWREADY, 1'b0);
    check_eq("rst_wready", WREADY, 1'b0);
    check_eq("rst_bvalid", BVALID, 1'b0);
    check_eq("rst_arready", ARREADY, 1'b0);
    check_eq("rst_rvalid", RVALID, 1'b0);
    check_eq("rst_rlast", RLAST, 1'b0);
    check_eq("rst_bid", BID, 4'h0);
    check_eq("rst_bresp", BRESP, 2'b00);
    check_eq("rst_rid", RID, 4'h0);
    check_eq("rst_rresp", RRESP, 2'b00);
    check_eq("rst_rdata", RDATA, 32'h0);
    rst_ni = 1'b1;
    tick();
    check_eq("awready_post_rst", AWREADY, 1'b1);
    check_eq("arready_post_rst", ARREADY, 1'b1);

    // single beat, and slave-select bits ignored on read
    do_write(32'h0000_0010, 8'd0, 2'b01, 1, 4'hF, 32'hDEADBEEF, 0);
    do_read (32'h0000_0010, 8'd0, 2'b01, 1'b0, -1);
    do_read (32'hF000_0010, 8'd0, 2'b01, 1'b0, -1);
    // INCR burst of 4
    do_write(32'h100, 8'd3, 2'b01, 4, 4'hF, 32'd1, 0);
    do_read (32'h100, 8'd3, 2'b01, 1'b0, -1);
    // partial strobe merge
    do_write(32'h20, 8'd0, 2'b01, 1, 4'hF, 32'h11223344, 0);
    do_write(32'h20, 8'd0, 2'b01, 1, 4'b0101, 32'hAABBCCDD, 0);
    do_read (32'h20, 8'd0, 2'b01, 1'b0, -1);
    // B back-pressure and R stalls
    do_write(32'h200, 8'd7, 2'b01, 8, 4'hF, 32'h100, 5);
    do_read (32'h200, 8'd7, 2'b01, 1'b1, -1);
    // out-of-range write must not alias onto word 0
    do_write(32'h0, 8'd0, 2'b01, 1, 4'hF, 32'h55AA55AA, 0);
    do_write(32'h1000, 8'd0, 2'b01, 1, 4'hF, 32'h12345678, 0);
    do_read (32'h0, 8'd0, 2'b01, 1'b0, -1);
    do_read (32'hFFC, 8'd1, 2'b01, 1'b0, -1);
    // early WLAST, and beats beyond AWLEN dropped
    do_write(32'h30, 8'd1, 2'b01, 1, 4'hF, 32'h66, 0);
    do_write(32'h44, 8'd0, 2'b01, 1, 4'hF, 32'h77, 0);
    do_write(32'h40, 8'd0, 2'b01, 3, 4'hF, 32'hA0, 0);
    do_read (32'h40, 8'd1, 2'b01, 1'b0, -1);
    // FIXED burst stays on one word
    do_write(32'h60, 8'd2, 2'b00, 3, 4'hF, 32'h9, 0);
    do_read (32'h60, 8'd1, 2'b01, 1'b0, -1);
    // WRAP flagged as error
    do_read (32'h100, 8'd1, 2'b10, 1'b0, -1);
    // reset in mid-read, then a clean read
    do_read (32'h200, 8'd7, 2'b01, 1'b0, 3);
    do_read (32'h200, 8'd1, 2'b01, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

AXI4 memory responder: the slave-side endpoint that hangs off any `sN_*` port of `axi_interconnect`. Accepts write bursts (AW/W) and returns B responses, and accepts read bursts (AR) and returns R beats, backed by an internal word-addressed RAM. Write and read paths are independent FSMs sharing the storage array. It gives the SoC a protocol-accurate memory target.

## Interface
Parameters (widths `ID_BITS`, `ADDR_WIDTH`, `LEN_BITS`, `SIZE_BITS`, `DATA_WIDTH` come from `define.sv`):
- DEPTH, 1024, number of DATA_WIDTH-bit words (power of two)

Ports (one clock; reset is synchronous and active-low):
- clk_i  in  1  clock, all state changes on rising edge
- rst_ni  in  1  synchronous active-low reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_BITS/ADDR_WIDTH/LEN_BITS/SIZE_BITS/2  write address
- AWVALID in 1, AWREADY out 1  write-address handshake
- WDATA/WSTRB/WLAST  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
- WVALID in 1, WREADY out 1  write-data handshake
- BID/BRESP  out  ID_BITS/2  write response
- BVALID out 1, BREADY in 1  response handshake
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  widths as AW  read address
- ARVALID in 1, ARREADY out 1  read-address handshake
- RID/RDATA/RRESP/RLAST  out  ID_BITS/DATA_WIDTH/2/1  read data
- RVALID out 1, RREADY in 1  read-data handshake

## Operation
- Address decode: top 4 address bits ignored (interconnect slave select). Word index = (addr[ADDR_WIDTH-5:0]) >> log2(DATA_WIDTH/8). Out of range if index >= DEPTH.
- Burst: FIXED (2'b00) keeps address; INCR (2'b01) adds 1<<SIZE per beat; WRAP (2'b10) and 2'b11 treated as INCR but flag SLVERR. SIZE > log2(DATA_WIDTH/8) flags SLVERR.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1; on AW handshake latch id/addr/len/size/burst, clear beat counter and error flag, go W_DATA.
  - W_DATA: WREADY=1; each W handshake writes bytes where WSTRB=1, advances address, increments counter. Out-of-range beat: write suppressed, error set. On handshake with WLAST=1 go W_RESP; error set if counter != AWLEN at that beat. WLAST=0 beyond AWLEN beats: keep accepting, error set, no write.
  - W_RESP: BVALID=1, BID=latched id, BRESP=2'b10 if error else 2'b00; on BREADY go W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1; on AR handshake latch fields, load RDATA from first word, go R_DATA.
  - R_DATA: RVALID=1, RID=latched id, RLAST=1 when beat counter == ARLEN. RRESP=2'b10 and RDATA=0 for out-of-range or illegal burst/size beats. On RREADY: if RLAST go R_IDLE, else load next beat's RDATA and counter+1.
- Memory contents not reset.

## Timing
- Reset: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BID, BRESP, RID, RRESP, RDATA = 0; both FSMs to IDLE. First cycle after reset release AWREADY=ARREADY=1.
- Reset mid-burst: burst abandoned, no B/R issued, partially written words keep written data.
- AW handshake at cycle N -> WREADY=1 at N+1. WLAST handshake at N -> BVALID at N+1. BVALID held stable until BREADY.
- AR handshake at N -> RVALID with beat 0 at N+1; one beat per cycle while RREADY=1. RID/RDATA/RLAST/RRESP stable while RVALID=1 and RREADY=0.
- One outstanding write and one outstanding read; AWREADY/ARREADY low outside IDLE.
- Same-cycle write beat and read load to same word: read returns old data.
- Beat counter LEN_BITS wide; FIXED bursts never advance address; INCR wraps modulo 2^ADDR_WIDTH (out-of-range check still applies).

## Test plan
Values: DATA_WIDTH=32, DEPTH=1024.
- Single write AWADDR=0x0000_0010, WDATA=0xDEADBEEF, WSTRB=4'hF, then read same -> BRESP=0, RDATA=0xDEADBEEF, RLAST=1 one cycle after AR handshake.
- INCR write AWLEN=3 from 0x100 with data 1..4, INCR read ARLEN=3 RREADY=1 -> RDATA 1,2,3,4 on consecutive cycles, RLAST only on 4th.
- Partial strobe: word holds 0x11223344, write 0xAABBCCDD WSTRB=4'b0101 -> read 0x11BB33DD.
- RREADY toggling 1/0 during ARLEN=7 read -> outputs hold while stalled, 8 beats in order, no beat lost; BREADY held 0 for 5 cycles -> BVALID/BID stable, AWREADY=0 throughout.
- Error: write to word index 1024 -> BRESP=2'b10, memory unchanged; AWLEN=1 with WLAST on beat 0 -> BRESP=2'b10; ARBURST=2'b10 -> RRESP=2'b10, RDATA=0.
- rst_ni=0 mid-read of ARLEN=7 at beat 3 -> next cycle RVALID=0, ARREADY=1 after release; new read completes normally.
